mod_exp_seq: RTL

Left-to-right square-and-multiply sequencer that computes `i_base^i_exp mod q` using one shared fixed-latency modular multiplier for GF(2^255-19).
- It sits between the scalar/inversion logic and the multiplier.
- It drives the multiplier's operand inputs and captures its result after a parameterised latency.
- Its main use is field inversion via Fermat (`exp = q-2`).

---
 rtl/mod_exp_seq.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mod_exp_seq.sv
// Left-to-right square-and-multiply sequencer driving one shared fixed-latency
// modular multiplier; computes base^exp mod q (field inversion via exp = q-2).
module mod_exp_seq #(
  parameter int unsigned W       = 256,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_base,
  input  logic [W-1:0] i_exp,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_result,
  output logic [W-1:0] o_mul_a,
  output logic [W-1:0] o_mul_b,
  input  logic [W-1:0] i_mul_c
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned LW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SCAN = 3'd1;
  localparam logic [2:0] S_SQR  = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state, state_n;
  logic [W-1:0]  e_reg, e_n;
  logic [CW-1:0] bit_cnt, cnt_n;
  logic [LW-1:0] lat_cnt, lat_n;
  logic [W-1:0]  base_reg, base_n;
  logic [W-1:0]  r_reg, r_n;
  logic [W-1:0]  mul_a, mul_b;
  logic          lat_last;

  assign lat_last = (lat_cnt == LW'(MUL_LAT - 1));

  always_comb begin
    state_n = state;
    e_n     = e_reg;
    cnt_n   = bit_cnt;
    lat_n   = lat_cnt;
    base_n  = base_reg;
    r_n     = r_reg;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          e_n     = i_exp;
          base_n  = i_base;
          cnt_n   = CW'(W);
          state_n = S_SCAN;
        end
      end
      S_SCAN: begin
        e_n   = e_reg << 1;
        cnt_n = bit_cnt - 1'b1;
        if (e_reg[W-1]) begin
          r_n     = base_reg;
          state_n = (cnt_n == '0) ? S_DONE : S_SQR;
        end else if (cnt_n == '0) begin
          r_n     = W'(1);
          state_n = S_DONE;
        end
      end
      S_SQR: begin
        if (lat_last) begin
          lat_n = '0;
          r_n   = i_mul_c;
          // A set bit is left in place so the MUL window consumes it.
          if (e_reg[W-1]) begin
            state_n = S_MUL;
          end else begin
            e_n     = e_reg << 1;
            cnt_n   = bit_cnt - 1'b1;
            state_n = (cnt_n == '0) ? S_DONE : S_SQR;
          end
        end else begin
          lat_n = lat_cnt + 1'b1;
        end
      end
      S_MUL: begin
        if (lat_last) begin
          lat_n   = '0;
          r_n     = i_mul_c;
          e_n     = e_reg << 1;
          cnt_n   = bit_cnt - 1'b1;
          state_n = (cnt_n == '0) ? S_DONE : S_SQR;
        end else begin
          lat_n = lat_cnt + 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      e_reg    <= '0;
      bit_cnt  <= '0;
      lat_cnt  <= '0;
      base_reg <= '0;
      r_reg    <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
    end else begin
      state    <= state_n;
      e_reg    <= e_n;
      bit_cnt  <= cnt_n;
      lat_cnt  <= lat_n;
      base_reg <= base_n;
      r_reg    <= r_n;
      // Operands load from next-state values so they are valid, and held,
      // from the first cycle of each SQR/MUL window.
      mul_a    <= (state_n == S_SQR || state_n == S_MUL) ? r_n : '0;
      mul_b    <= (state_n == S_SQR) ? r_n : ((state_n == S_MUL) ? base_n : '0);
    end
  end

  assign o_busy   = (state != S_IDLE);
  assign o_done   = (state == S_DONE);
  assign o_result = r_reg;
  assign o_mul_a  = mul_a;
  assign o_mul_b  = mul_b;

endmodule
